// File: rtl/core_pkg.sv
// Shared types and constants for the core front end.
package core_pkg;

    typedef enum logic [1:0] {
        RUN,
        MISS,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] RESET_VEC_DEF = 32'hBFC00000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'hBFC00180;
    localparam int          INSTR_BYTES   = 4;

endpackage

// File: rtl/fetch_ctrl_tgt_sel.sv
// Redirect target select and alignment for fetch_ctrl.
// FETCH_MISALIGN_EN: misaligned targets trap to TRAP_VEC instead of being truncated.
module fetch_tgt_sel
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(TRAP_VEC_DEF)
) (
    input  logic [XLEN-1:0] target_raw_i,
    output logic [XLEN-1:0] target_o,
    output logic            misalign_o
);

`ifdef FETCH_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    // Disabled build: low bits are dropped, so the target is always word aligned.
    always_comb begin
        misalign_o = MISALIGN_EN && (target_raw_i[1:0] != 2'b00);
        target_o   = misalign_o ? TRAP_VEC : {target_raw_i[XLEN-1:2], 2'b00};
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter sequencer: redirect > stall > imem miss > PC+4.
// Optional FETCH_MISALIGN_EN: misaligned redirects go to TRAP_VEC and pulse misalign_o.
module fetch_ctrl
    import core_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_pc4_o,
    output logic            flush_o,
    output logic            misalign_o
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] target;
    logic            target_mis;
    logic [XLEN-1:0] pc_plus4;

    fetch_tgt_sel #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC)
    ) u_tgt_sel (
        .target_raw_i (redirect_target_i),
        .target_o     (target),
        .misalign_o   (target_mis)
    );

    assign pc_plus4    = pc_q + XLEN'(INSTR_BYTES);
    assign imem_addr_o = pc_q;
    assign if_pc_o     = pc_q;
    assign if_pc4_o    = pc_plus4;

    // NOTE: every output and _d signal gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        imem_req_o = !rst;
        if_valid_o = 1'b0;
        flush_o    = 1'b0;
        misalign_o = 1'b0;

        if (!rst) begin
            misalign_o = redirect_i && target_mis;
            unique case (state_q)
                RUN: begin
                    if (redirect_i) begin
                        flush_o = 1'b1;
                        if (imem_ready_i || stall_i) begin
                            pc_d = target;
                        end else begin
                            tgt_d   = target;
                            state_d = DRAIN;
                        end
                    end else if (!stall_i) begin
                        if (!imem_ready_i) begin
                            state_d = MISS;
                        end else begin
                            if_valid_o = 1'b1;
                            pc_d       = pc_plus4;
                        end
                    end
                end
                MISS: begin
                    if (redirect_i) begin
                        flush_o = 1'b1;
                        tgt_d   = target;
                        if (imem_ready_i) begin
                            pc_d    = target;
                            state_d = RUN;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (imem_ready_i) begin
                        state_d = RUN;
                        if (!stall_i) begin
                            if_valid_o = 1'b1;
                            pc_d       = pc_plus4;
                        end
                    end
                end
                DRAIN: begin
                    // The stale miss must complete; its data is dropped on arrival.
                    if (redirect_i) begin
                        flush_o = 1'b1;
                        tgt_d   = target;
                    end
                    if (imem_ready_i) begin
                        pc_d    = redirect_i ? target : tgt_q;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VEC;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl; fetched PCs are scoreboarded against expected order.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'hBFC00000;
    localparam logic [31:0] TV = 32'hBFC00180;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_target_i;
    logic        stall_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc4_o;
    logic        flush_o;
    logic        misalign_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_e;

    fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_i        (redirect_i),
        .redirect_target_i (redirect_target_i),
        .stall_i           (stall_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ready_i      (imem_ready_i),
        .if_valid_o        (if_valid_o),
        .if_pc_o           (if_pc_o),
        .if_pc4_o          (if_pc4_o),
        .flush_o           (flush_o),
        .misalign_o        (misalign_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every IF/ID write must match the next expected PC.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (flush_o && if_valid_o) begin
                errors++;
                $display("FAIL flush_with_valid at %0t: flush_o and if_valid_o both 1", $time);
            end
            if (if_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got valid pc %h, expected no fetch", if_pc_o);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (if_pc_o !== sb_e || if_pc4_o !== sb_e + 32'd4) begin
                        errors++;
                        $display("FAIL sb_pc: got pc %h pc4 %h, expected pc %h pc4 %h",
                                 if_pc_o, if_pc4_o, sb_e, sb_e + 32'd4);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic [31:0] t, input logic s, input logic y);
        redirect_i        = r;
        redirect_target_i = t;
        stall_i           = s;
        imem_ready_i      = y;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_i = 1'b0; redirect_target_i = '0; stall_i = 1'b0; imem_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_i = 1'b0; imem_ready_i = 1'b1; redirect_target_i = 32'hBFC00100;
        for (int i = 0; i < 2; i++) begin
            redirect_i = (i == 1);
            @(negedge clk);
            checks++;
            if ({imem_req_o, if_valid_o, flush_o, misalign_o} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_outputs: got req/valid/flush/mis %b, expected 0000",
                         {imem_req_o, if_valid_o, flush_o, misalign_o});
            end
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(RV + 32'(4 * i));
            cyc(1'b0, '0, 1'b0, 1'b1);
            checks++;
            if (imem_addr_o !== RV + 32'(4 * i) || if_valid_o !== 1'b1 || imem_req_o !== 1'b1) begin
                errors++;
                $display("FAIL reset_seq[%0d]: got addr %h valid %b req %b, expected addr %h valid 1 req 1",
                         i, imem_addr_o, if_valid_o, imem_req_o, RV + 32'(4 * i));
            end
            tick();
        end
        exp_q.push_back(RV + 32'hC);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== RV + 32'hC) begin
            errors++;
            $display("FAIL reset_pc3: got addr %h, expected %h", imem_addr_o, RV + 32'hC);
        end
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(RV + 32'(4 * i));
            cyc(1'b0, '0, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b1);
            checks++;
            if (imem_addr_o !== RV + 32'h8 || if_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got addr %h valid %b, expected addr %h valid 0",
                         i, imem_addr_o, if_valid_o, RV + 32'h8);
            end
            tick();
        end
        exp_q.push_back(RV + 32'h8);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== RV + 32'h8 || if_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got addr %h valid %b, expected addr %h valid 1",
                     imem_addr_o, if_valid_o, RV + 32'h8);
        end
        tick();
        exp_q.push_back(RV + 32'hC);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== RV + 32'hC) begin
            errors++;
            $display("FAIL stall_next: got addr %h, expected %h", imem_addr_o, RV + 32'hC);
        end
        tick();
    endtask

    task automatic test_miss();
        do_reset();
        exp_q.push_back(RV);
        cyc(1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b0);
            checks++;
            if (imem_addr_o !== RV + 32'h4 || if_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin
                errors++;
                $display("FAIL miss_hold[%0d]: got addr %h valid %b req %b, expected addr %h valid 0 req 1",
                         i, imem_addr_o, if_valid_o, imem_req_o, RV + 32'h4);
            end
            tick();
        end
        exp_q.push_back(RV + 32'h4);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (if_valid_o !== 1'b1 || imem_addr_o !== RV + 32'h4) begin
            errors++;
            $display("FAIL miss_ready: got addr %h valid %b, expected addr %h valid 1",
                     imem_addr_o, if_valid_o, RV + 32'h4);
        end
        tick();
        exp_q.push_back(RV + 32'h8);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== RV + 32'h8) begin
            errors++;
            $display("FAIL miss_next: got addr %h, expected %h", imem_addr_o, RV + 32'h8);
        end
        tick();
    endtask

    task automatic test_redirect_run();
        do_reset();
        exp_q.push_back(RV);
        cyc(1'b0, '0, 1'b0, 1'b1);
        tick();
        cyc(1'b1, 32'hBFC00100, 1'b0, 1'b1);
        checks++;
        if (flush_o !== 1'b1 || if_valid_o !== 1'b0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_run: got flush %b valid %b mis %b, expected flush 1 valid 0 mis 0",
                     flush_o, if_valid_o, misalign_o);
        end
        tick();
        exp_q.push_back(32'hBFC00100);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== 32'hBFC00100 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL redir_run_next: got addr %h flush %b, expected addr bfc00100 flush 0",
                     imem_addr_o, flush_o);
        end
        tick();
    endtask

    task automatic test_redirect_miss();
        do_reset();
        exp_q.push_back(RV);
        cyc(1'b0, '0, 1'b0, 1'b1);
        tick();
        cyc(1'b0, '0, 1'b0, 1'b0);
        tick();
        cyc(1'b1, 32'hBFC00200, 1'b0, 1'b0);
        checks++;
        if (flush_o !== 1'b1 || if_valid_o !== 1'b0 || imem_addr_o !== RV + 32'h4) begin
            errors++;
            $display("FAIL redir_miss: got flush %b valid %b addr %h, expected flush 1 valid 0 addr %h",
                     flush_o, if_valid_o, imem_addr_o, RV + 32'h4);
        end
        tick();
        cyc(1'b1, 32'hBFC00300, 1'b0, 1'b0);
        checks++;
        if (flush_o !== 1'b1 || imem_addr_o !== RV + 32'h4) begin
            errors++;
            $display("FAIL redir_drain: got flush %b addr %h, expected flush 1 addr %h",
                     flush_o, imem_addr_o, RV + 32'h4);
        end
        tick();
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (if_valid_o !== 1'b0 || flush_o !== 1'b0 || imem_addr_o !== RV + 32'h4) begin
            errors++;
            $display("FAIL drain_discard: got valid %b flush %b addr %h, expected valid 0 flush 0 addr %h",
                     if_valid_o, flush_o, imem_addr_o, RV + 32'h4);
        end
        tick();
        exp_q.push_back(32'hBFC00300);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== 32'hBFC00300) begin
            errors++;
            $display("FAIL drain_target: got addr %h, expected bfc00300", imem_addr_o);
        end
        tick();
    endtask

    task automatic test_misalign();
        logic        exp_mis;
        logic [31:0] exp_tgt;
`ifdef FETCH_MISALIGN_EN
        exp_mis = 1'b1;
        exp_tgt = TV;
`else
        exp_mis = 1'b0;
        exp_tgt = 32'hBFC00100;
`endif
        do_reset();
        exp_q.push_back(RV);
        cyc(1'b0, '0, 1'b0, 1'b1);
        tick();
        cyc(1'b1, 32'hBFC00102, 1'b0, 1'b1);
        checks++;
        if (misalign_o !== exp_mis || flush_o !== 1'b1) begin
            errors++;
            $display("FAIL misalign_pulse: got mis %b flush %b, expected mis %b flush 1",
                     misalign_o, flush_o, exp_mis);
        end
        tick();
        exp_q.push_back(exp_tgt);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== exp_tgt || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL misalign_target: got addr %h mis %b, expected addr %h mis 0",
                     imem_addr_o, misalign_o, exp_tgt);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.push_back(RV);
        cyc(1'b0, '0, 1'b0, 1'b1);
        tick();
        // Redirect beats stall and miss in RUN: no DRAIN, target taken directly.
        cyc(1'b1, 32'hBFC00400, 1'b1, 1'b0);
        tick();
        exp_q.push_back(32'hBFC00400);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== 32'hBFC00400 || if_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL redir_stall: got addr %h valid %b, expected addr bfc00400 valid 1",
                     imem_addr_o, if_valid_o);
        end
        tick();
        cyc(1'b0, '0, 1'b0, 1'b0);
        tick();
        cyc(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (if_valid_o !== 1'b0 || imem_addr_o !== 32'hBFC00404) begin
            errors++;
            $display("FAIL miss_stall: got valid %b addr %h, expected valid 0 addr bfc00404",
                     if_valid_o, imem_addr_o);
        end
        tick();
        exp_q.push_back(32'hBFC00404);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (if_valid_o !== 1'b1 || imem_addr_o !== 32'hBFC00404) begin
            errors++;
            $display("FAIL miss_stall_refetch: got valid %b addr %h, expected valid 1 addr bfc00404",
                     if_valid_o, imem_addr_o);
        end
        tick();
        cyc(1'b1, 32'hBFC00500, 1'b0, 1'b0);
        tick();
        cyc(1'b1, 32'hBFC00600, 1'b0, 1'b1);
        checks++;
        if (flush_o !== 1'b1 || if_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_redir_ready: got flush %b valid %b, expected flush 1 valid 0",
                     flush_o, if_valid_o);
        end
        tick();
        exp_q.push_back(32'hBFC00600);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== 32'hBFC00600) begin
            errors++;
            $display("FAIL drain_latest: got addr %h, expected bfc00600", imem_addr_o);
        end
        tick();
        cyc(1'b1, 32'hFFFFFFFC, 1'b0, 1'b1);
        tick();
        exp_q.push_back(32'hFFFFFFFC);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (if_pc4_o !== 32'h0) begin
            errors++;
            $display("FAIL pc4_wrap: got pc4 %h, expected 00000000", if_pc4_o);
        end
        tick();
        exp_q.push_back(32'h0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: got addr %h, expected 00000000", imem_addr_o);
        end
        tick();
        // Reset in MISS with a redirect present must still win.
        cyc(1'b0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        cyc(1'b1, 32'hBFC00700, 1'b0, 1'b0);
        checks++;
        if ({imem_req_o, if_valid_o, flush_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_miss: got req/valid/flush %b, expected 000",
                     {imem_req_o, if_valid_o, flush_o});
        end
        tick();
        rst = 1'b0;
        exp_q.push_back(RV);
        cyc(1'b0, '0, 1'b0, 1'b1);
        checks++;
        if (imem_addr_o !== RV || if_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_miss_restart: got addr %h valid %b, expected addr %h valid 1",
                     imem_addr_o, if_valid_o, RV);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        redirect_i = 1'b0; redirect_target_i = '0; stall_i = 1'b0; imem_ready_i = 1'b1;
        tick();
        test_reset();
        test_stall();
        test_miss();
        test_redirect_run();
        test_redirect_miss();
        test_misalign();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d unfetched entries, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
